mult_accum_fu: RTL and testbench
================================

Name: mult_accum_fu

Overview:
- Downstream consumer of the scalar multiplier FU in the s_tile.
- Takes the multiplier's product (c) with its ack as a valid strobe, and accumulates a programmed number of products into a wide unsigned accumulator.
- Presents the sum on a valid/ready output port; result is held until taken.
- Completes the scalar MAC/dot-product path of the tile.

Parameters:
- IN_WIDTH, 64, product width; matches the multiplier out_width.
- ACC_WIDTH, 72, accumulator width; must be >= IN_WIDTH.
- CNT_WIDTH, 8, width of the term-count field (max 2^CNT_WIDTH-1 terms).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- on_off  in  1  FU enable. When 0, no input accepts and no start; output handshake unaffected.
- start  in  1  begin a new accumulation; sampled only in IDLE.
- len  in  CNT_WIDTH  number of products to accumulate; latched on start.
- in_valid  in  1  product valid; driven by the multiplier ack.
- in_data  in  IN_WIDTH  product; driven by the multiplier c.
- in_ready  out  1  product accepted on a cycle where in_valid & in_ready.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_sum  out  ACC_WIDTH  accumulated sum.
- out_ovf  out  1  sticky overflow flag for this result.
- busy  out  1  high in ACCUM or DONE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; acc, count, len_q all 0; ovf=0.
  - All outputs 0: in_ready, out_valid, out_sum, out_ovf, busy.
  - Reset mid-operation aborts immediately; a partial sum is discarded, never emitted.
- State IDLE:
  - in_ready=0, out_valid=0.
  - on start & on_off: latch len_q=len; clear acc, count and ovf.
  - If len==0, go to DONE (sum 0); else go to ACCUM.
- State ACCUM:
  - in_ready = on_off (combinational from state and on_off).
  - Accept = in_valid & in_ready.
  - On accept: acc <= acc + zero-extend(in_data), unsigned; count++.
  - If the ACC_WIDTH-bit add carries out: acc <= all-ones and ovf <= 1.
  - Once ovf=1, acc stays all-ones for the rest of the run.
  - On the accept where count==len_q-1, go to DONE.
  - in_valid while in_ready=0 is ignored and not counted; the multiplier re-presents it.
- State DONE:
  - out_valid=1; out_sum=acc and out_ovf=ovf, both stable while out_valid=1.
  - in_ready=0.
  - On out_valid & out_ready, go to IDLE; out_valid drops the next cycle.
- Outputs are registered.
- Latency: out_valid rises the cycle after the final accept (len=0: the cycle after start).
- start outside IDLE is ignored; len changes after start are ignored.
- A new start is possible the cycle after the result is taken.
- on_off=0 in ACCUM freezes acc and count; accumulation resumes when on_off returns to 1.
- busy = (state != IDLE).

Test Plan:
- Reset, then start with len=3, feeding products 6, 0x10, 0x100 back-to-back, with out_ready=1 -> out_valid one cycle after the 3rd accept; out_sum=0x116, out_ovf=0; IDLE the next cycle.
- len=2, products 0x0B00EA4E242D2080 then 0xFFFFFFFE00000001 -> out_sum=0x010B00EA4C242D2081 (72-bit), out_ovf=0.
- Instance with ACC_WIDTH=64, len=2, both products 0xFFFFFFFE00000001 -> out_sum=0xFFFFFFFFFFFFFFFF, out_ovf=1.
- len=2 with on_off=0 for 3 cycles between products while in_valid=1 -> in_ready=0 and no accepts during the gap; final out_sum equals the sum of exactly 2 products.
- Hold out_ready=0 for 4 cycles in DONE, with start pulsed -> out_valid and out_sum held, start ignored; out_ready=1 -> IDLE. len=0 start -> out_sum=0 the next cycle.
- Assert reset mid-ACCUM after 1 of 3 products -> all outputs 0 immediately; a subsequent len=1 run with product 5 gives out_sum=5.

Source files
------------

// File: rtl/mult_accum_fu.sv
// mult_accum_fu: accumulates a programmed number of multiplier products into a wide
// saturating unsigned sum and presents the result on a valid/ready port.
module mult_accum_fu #(
    parameter int IN_WIDTH  = 64,
    parameter int ACC_WIDTH = 72,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 on_off,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] len,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic                 out_ovf,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, len_q, len_d;
    logic                 ovf_q, ovf_d;
    logic [ACC_WIDTH:0]   sum;
    logic                 accept;
    always_comb begin
        in_ready = (state_q == ACCUM) && on_off;
        accept   = in_valid && in_ready;
        sum      = {1'b0, acc_q} + (ACC_WIDTH+1)'(in_data);
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: if (start && on_off) begin
                len_d   = len;
                acc_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
                state_d = (len == '0) ? DONE : ACCUM;
            end
            ACCUM: if (accept) begin
                // once saturated the sum is pinned at all-ones for the rest of the run
                ovf_d = ovf_q || sum[ACC_WIDTH];
                acc_d = ovf_d ? '1 : sum[ACC_WIDTH-1:0];
                cnt_d = cnt_q + ONE;
                if (cnt_q == len_q - ONE) state_d = DONE;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;
endmodule

// File: tb/tb_mult_accum_fu.sv
// tb_mult_accum_fu: directed scoreboard bench for mult_accum_fu (72-bit and 64-bit accumulators).
module tb_mult_accum_fu;
    logic        clk = 0;
    logic        reset = 0;
    logic        on_off = 1;
    logic        start = 0;
    logic [7:0]  len = 0;
    logic        in_valid = 0;
    logic [63:0] in_data = 0;
    logic        in_ready, out_valid, out_ovf, busy;
    logic        out_ready = 1;
    logic [71:0] out_sum;
    logic        b_on_off = 1;
    logic        b_start = 0;
    logic [7:0]  b_len = 0;
    logic        b_in_valid = 0;
    logic [63:0] b_in_data = 0;
    logic        b_in_ready, b_out_valid, b_out_ovf, b_busy;
    logic        b_out_ready = 1;
    logic [63:0] b_out_sum;
    int total = 0;
    int bad = 0;
    logic [72:0] a_exp[$];
    logic [64:0] b_exp[$];

    always #5 clk = ~clk;

    mult_accum_fu dut_a (
        .clk(clk), .reset(reset), .on_off(on_off), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_ovf(out_ovf), .busy(busy)
    );

    mult_accum_fu #(.IN_WIDTH(64), .ACC_WIDTH(64), .CNT_WIDTH(8)) dut_b (
        .clk(clk), .reset(reset), .on_off(b_on_off), .start(b_start), .len(b_len),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum),
        .out_ovf(b_out_ovf), .busy(b_busy)
    );

    task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (a_exp.size() == 0) chk("a_unexpected_result", 73'(out_sum), 73'h0);
            else chk("a_result", {out_ovf, out_sum}, a_exp.pop_front());
        end
        if (reset && b_out_valid && b_out_ready) begin
            if (b_exp.size() == 0) chk("b_unexpected_result", 73'(b_out_sum), 73'h0);
            else chk("b_result", 73'({b_out_ovf, b_out_sum}), 73'(b_exp.pop_front()));
        end
    end

    task automatic do_start(input logic [7:0] l);
        start = 1;
        len = l;
        @(posedge clk) #1;
        start = 0;
        len = 8'hAA;
    endtask

    task automatic feed(input logic [63:0] d);
        int n = 0;
        in_valid = 1;
        in_data = d;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk("feed_timeout", 73'(in_ready), 73'h1);
        @(posedge clk) #1;
        in_valid = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 73'(out_valid), 73'h0);
        chk("rst_out_sum", 73'(out_sum), 73'h0);
        chk("rst_misc", {70'h0, busy, in_ready, out_ovf}, 73'h0);
        chk("rst_b_out_valid", 73'(b_out_valid), 73'h0);
        reset = 1;
        @(posedge clk) #1;

        a_exp.push_back({1'b0, 72'h116});
        do_start(8'd3);
        feed(64'h6);
        feed(64'h10);
        feed(64'h100);
        @(negedge clk);
        chk("t1_latency_valid", 73'(out_valid), 73'h1);
        chk("t1_done_in_ready", 73'(in_ready), 73'h0);
        @(negedge clk);
        chk("t1_idle_after", {71'h0, out_valid, busy}, 73'h0);
        @(posedge clk) #1;

        a_exp.push_back({1'b0, 72'h010B00EA4C242D2081});
        do_start(8'd2);
        feed(64'h0B00EA4E242D2080);
        feed(64'hFFFFFFFE00000001);
        @(negedge clk);
        @(posedge clk) #1;

        b_exp.push_back({1'b1, 64'hFFFFFFFFFFFFFFFF});
        b_start = 1;
        b_len = 8'd2;
        @(posedge clk) #1;
        b_start = 0;
        b_in_valid = 1;
        b_in_data = 64'hFFFFFFFE00000001;
        @(posedge clk) #1;
        @(posedge clk) #1;
        b_in_valid = 0;
        @(negedge clk);
        chk("t3_b_valid", 73'(b_out_valid), 73'h1);
        @(posedge clk) #1;

        a_exp.push_back({1'b0, 72'h31});
        do_start(8'd2);
        feed(64'h11);
        on_off = 0;
        in_valid = 1;
        in_data = 64'h7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_gap_in_ready", 73'(in_ready), 73'h0);
            chk("t4_gap_busy", 73'(busy), 73'h1);
            @(posedge clk) #1;
        end
        on_off = 1;
        feed(64'h20);
        @(negedge clk);
        @(posedge clk) #1;

        out_ready = 0;
        a_exp.push_back({1'b0, 72'h55});
        do_start(8'd1);
        feed(64'h55);
        start = 1;
        len = 8'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_hold_valid", 73'(out_valid), 73'h1);
            chk("t5_hold_sum", 73'(out_sum), 73'h55);
            @(posedge clk) #1;
        end
        start = 0;
        out_ready = 1;
        @(posedge clk) #1;
        @(negedge clk);
        chk("t5_idle_after_take", 73'(out_valid), 73'h0);
        @(posedge clk) #1;
        a_exp.push_back({1'b0, 72'h0});
        do_start(8'd0);
        @(negedge clk);
        chk("t5_len0_valid", 73'(out_valid), 73'h1);
        chk("t5_len0_sum", 73'(out_sum), 73'h0);
        @(posedge clk) #1;

        do_start(8'd3);
        feed(64'h9);
        reset = 0;
        #1;
        chk("t6_rst_outs", {70'h0, out_valid, busy, in_ready}, 73'h0);
        chk("t6_rst_sum", {out_ovf, out_sum}, 73'h0);
        @(posedge clk) #1;
        reset = 1;
        @(posedge clk) #1;
        a_exp.push_back({1'b0, 72'h5});
        do_start(8'd1);
        feed(64'h5);

        for (int i = 0; i < 20 && (a_exp.size() + b_exp.size()) != 0; i++) @(negedge clk);
        chk("drain_pending", 73'(a_exp.size() + b_exp.size()), 73'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
